// File: rtl/grid_env_if.sv
// grid_env_if: control-unit/agent side signals of the grid environment
interface grid_env_if;
  logic [3:0] controller;
  logic [3:0] step;
  logic [1:0] action;
  logic act_valid;
  logic act_ready;
  logic [3:0] st;
  logic [3:0] st1;
  logic [7:0] reward;
  logic done;
  logic rwd_valid;
  logic [11:0] ep_return;
  logic [11:0] goal_cnt;
  logic [7:0] miss_cnt;
  modport master (
    output controller, step, action, act_valid,
    input act_ready, st, st1, reward, done, rwd_valid, ep_return, goal_cnt, miss_cnt
  );
  modport slave (
    input controller, step, action, act_valid,
    output act_ready, st, st1, reward, done, rwd_valid, ep_return, goal_cnt, miss_cnt
  );
endinterface

// File: rtl/grid_env.sv
// grid_env: 2x5 grid-world environment stepped by the control unit's phase counter
module grid_env (
  input logic clk,
  input logic rst,
  grid_env_if.slave bus
);
  logic [3:0] st, st1, c;
  logic [7:0] reward, miss_cnt, mv_rwd;
  logic [11:0] ep_return, goal_cnt, ret_nxt;
  logic [12:0] sum;
  logic done, rwd_valid, armed, lat, arrive, act_ready, row, wall;
  logic [1:0] act;
  logic [2:0] col;
  logic [3:0] dest;
  assign c = bus.controller;
  // armed blocks all phase activity after reset until a fresh controller==1
  assign act_ready = armed && !lat && c >= 4'd2 && c <= 4'd4;
  always_comb begin
    row = st >= 4'd5;
    col = row ? 3'(st - 4'd5) : st[2:0];
    wall = (act == 2'd0 && !row) || (act == 2'd1 && row) ||
           (act == 2'd2 && col == 3'd0) || (act == 2'd3 && col == 3'd4);
    dest = wall ? st : act == 2'd0 ? st - 4'd5 : act == 2'd1 ? st + 4'd5 :
           act == 2'd2 ? st - 4'd1 : st + 4'd1;
    mv_rwd = wall ? 8'hFE : dest == 4'd7 ? 8'hF6 : dest == 4'd9 ? 8'h0A : 8'hFF;
    sum = {ep_return[11], ep_return} + {{5{reward[7]}}, reward};
    ret_nxt = sum[12] != sum[11] ? (sum[12] ? 12'h800 : 12'h7FF) : sum[11:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '0;
      st1 <= '0;
      reward <= '0;
      done <= 1'b0;
      rwd_valid <= 1'b0;
      ep_return <= '0;
      goal_cnt <= '0;
      miss_cnt <= '0;
      armed <= 1'b0;
      lat <= 1'b0;
      act <= '0;
      arrive <= 1'b0;
    end else begin
      rwd_valid <= 1'b0;
      if (c == 4'd1) begin
        armed <= 1'b1;
        lat <= 1'b0;
        if (bus.step == 4'd0) begin
          st <= '0;
          ep_return <= '0;
        end
      end
      if (act_ready && bus.act_valid) begin
        lat <= 1'b1;
        act <= bus.action;
      end
      if (armed && c == 4'd5) begin
        rwd_valid <= 1'b1;
        st1 <= st == 4'd9 ? 4'd9 : !lat ? st : dest == 4'd7 ? 4'd0 : dest;
        reward <= (st == 4'd9 || !lat) ? 8'h00 : mv_rwd;
        done <= st == 4'd9 || (lat && dest == 4'd9);
        arrive <= st != 4'd9 && lat && dest == 4'd9;
        miss_cnt <= miss_cnt + {7'd0, st != 4'd9 && !lat && miss_cnt != 8'hFF};
      end
      if (armed && c == 4'd10) begin
        st <= st1;
        ep_return <= ret_nxt;
        goal_cnt <= goal_cnt + {11'd0, arrive};
      end
    end
  end
  assign bus.act_ready = act_ready;
  assign bus.st = st;
  assign bus.st1 = st1;
  assign bus.reward = reward;
  assign bus.done = done;
  assign bus.rwd_valid = rwd_valid;
  assign bus.ep_return = ep_return;
  assign bus.goal_cnt = goal_cnt;
  assign bus.miss_cnt = miss_cnt;
endmodule

// File: doc/grid_env.md
GRID_ENV -- requirements
Module: grid_env

Interface
REQ-001 clk  input  1  rising-edge clock, shared with the control unit.
REQ-002 rst  input  1  reset; synchronous, active-high; clock clk.
REQ-003 controller  input  4  phase counter from the control unit; 0 after reset, then cycles 1..10.
REQ-004 step  input  4  step index within the episode; 0 means first step of an episode.
REQ-005 action  input  2  agent action: 0 up, 1 down, 2 left, 3 right.
REQ-006 act_valid  input  1  action offer from the agent.
REQ-007 act_ready  output  1  high while controller is 2..4 and no action is latched yet this step.
REQ-008 st  output  4  current state, 0..9.
REQ-009 st1  output  4  next state, fed back to the control unit.
REQ-010 reward  output  8  signed two's-complement reward for the current step.
REQ-011 done  output  1  high when st1 is the terminal state 9.
REQ-012 rwd_valid  output  1  one-cycle pulse while st1, reward and done are newly valid.
REQ-013 ep_return  output  12  signed accumulated reward of the current episode.
REQ-014 goal_cnt  output  12  count of goal arrivals since reset.
REQ-015 miss_cnt  output  8  count of steps with no action, saturating at 255.

Function
REQ-016 Grid geometry: 2 rows x 5 columns; row = st/5, col = st%5; start state 0; pit state 7; goal/terminal state 9.
REQ-017 Episode start: on a clock edge with controller==1 and step==0, st SHALL load 0 and ep_return SHALL clear to 0.
REQ-018 Step start: on every edge with controller==1, the action latch SHALL clear.
REQ-019 Handshake:
- Transfer occurs on an edge where act_valid and act_ready are both high.
- Only the first transfer per step is latched.
- Offers outside controller 2..4 are ignored.
REQ-020 Move rules:
- Up from row 1 gives st-5.
- Down from row 0 gives st+5.
- Left from col>0 gives st-1.
- Right from col<4 gives st+1.
- Any other move is a wall hit and the state is unchanged.
REQ-021 Rewards:
- Wall hit: -2.
- Ordinary move: -1.
- Entering pit 7: -10, and st1 SHALL be forced to 0.
- Entering 9: +10, with done=1.
REQ-022 Missed action: if no action is latched by the edge with controller==5, then st1=st, reward=0, done=0, and miss_cnt increments.
REQ-023 Evaluation timing:
- st1, reward and done register on the edge with controller==5, so they are valid from controller==6.
- They hold until the next controller==5 edge.
- rwd_valid is high only during controller==6.
REQ-024 Commit: on the edge with controller==10:
- st SHALL load st1.
- ep_return SHALL add reward, with signed saturation at +2047/-2048.
- goal_cnt SHALL increment if done, wrapping at 4095.
REQ-025 If st==9 at evaluation (terminal state not yet restarted), the step SHALL be a no-op: st1=9, reward=0, done=1. In this case goal_cnt does not increment.
REQ-026 controller==0 or values 11..15: no state change and no handshake; act_ready=0.
REQ-027 Reward and return arithmetic SHALL be signed; reward is sign-extended to 12 bits before accumulation.

Reset
REQ-028 While rst is high at an edge, all outputs SHALL be 0: st, st1, reward, done, rwd_valid, act_ready, ep_return, goal_cnt, miss_cnt. The action latch SHALL also clear.
REQ-029 rst SHALL take priority over all phase activity, including reset mid-step; operation resumes from the next controller==1.

Verification
REQ-030 Reset, then step 0 with action 3 offered at controller 2 -> act_ready falls after the transfer; at controller 6: st1=1, reward=-1, rwd_valid=1; after controller 10: st=1, ep_return=-1.
REQ-031 From st=4, action 3 -> wall hit: st1=4, reward=-2, done=0.
REQ-032 From st=2, action 1 -> pit: st1=0, reward=-10; after commit: st=0, ep_return decreases by 10.
REQ-033 From st=8, action 3 -> st1=9, reward=+10, done=1; after commit goal_cnt increments; at next controller 1 with step 0: st=0, ep_return=0.
REQ-034 No act_valid during controller 2..4 -> st1=st, reward=0, miss_cnt+1; an action offered at controller 5 is ignored.
REQ-035 Two offers in one step (action 0 at phase 2, action 3 at phase 3) -> only action 0 is used; assert rst at controller 7 -> all outputs 0 on the next edge.
